// File: rtl/fetch_buffer_pkg.sv
// Shared micro-op header: fetch/decode bundle widths, buffer depth and the
// per-slot instruction entry carried from fetch to decode.
package fetch_buffer_pkg;

    localparam int unsigned FETCH_WIDTH  = 4;
    localparam int unsigned DECODE_WIDTH = 4;
    localparam int unsigned FB_DEPTH     = 16;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_addr;
    } fb_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake: enqueue bundle with stall back-pressure,
// dequeue bundle with decode_ready.
interface fetch_buffer_if #(
    parameter int unsigned FW = fetch_buffer_pkg::FETCH_WIDTH,
    parameter int unsigned DW = fetch_buffer_pkg::DECODE_WIDTH
);
    import fetch_buffer_pkg::*;

    fb_entry_t insts_in [FW];
    logic      insts_in_valid;
    logic      stall;
    logic      decode_ready;
    fb_entry_t insts_out [DW];

    modport master (
        output insts_in, insts_in_valid, decode_ready,
        input  stall, insts_out
    );

    modport slave (
        input  insts_in, insts_in_valid, decode_ready,
        output stall, insts_out
    );

endinterface

// File: rtl/fetch_buffer_compact.sv
// Combinational compaction: per-slot write offset (prefix count of valid
// slots below it) and the total number of valid slots.
module fb_compact #(
    parameter int unsigned FW = fetch_buffer_pkg::FETCH_WIDTH,
    parameter int unsigned OW = (FW > 1) ? $clog2(FW) : 1
) (
    input  logic [FW-1:0] valid_i,
    output logic [OW-1:0] offset_o [FW],
    output logic [OW:0]   n_in_o
);

    logic [OW:0] run;

    always_comb begin
        run = '0;
        for (int unsigned i = 0; i < FW; i++) begin
            offset_o[i] = run[OW-1:0];
            run         = run + {{OW{1'b0}}, valid_i[i]};
        end
        n_in_o = run;
    end

endmodule

// File: rtl/fetch_buffer.sv
// Circular fetch buffer between fetch and decode: compacted multi-slot
// enqueue, in-order multi-slot dequeue, flush/reset squash all entries.
module fetch_buffer #(
    parameter int unsigned DEPTH        = fetch_buffer_pkg::FB_DEPTH,
    parameter int unsigned FETCH_WIDTH  = fetch_buffer_pkg::FETCH_WIDTH,
    parameter int unsigned DECODE_WIDTH = fetch_buffer_pkg::DECODE_WIDTH
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    fetch_buffer_if.slave  fb
);
    import fetch_buffer_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    fb_entry_t              mem_q [DEPTH];
    logic [PW-1:0]          head_q, head_d;
    logic [PW-1:0]          tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          n_in, n_out;
    logic [FETCH_WIDTH-1:0] slot_valid;
    logic [OW-1:0]          wr_off [FETCH_WIDTH];
    logic [OW:0]            n_in_raw;
    logic                   accept, deq;

    always_comb begin
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            slot_valid[i] = fb.insts_in[i].valid;
        end
    end

    fb_compact #(
        .FW (FETCH_WIDTH),
        .OW (OW)
    ) u_compact (
        .valid_i  (slot_valid),
        .offset_o (wr_off),
        .n_in_o   (n_in_raw)
    );

    // Equivalent to (DEPTH - count) < FETCH_WIDTH without unsigned underflow
    assign fb.stall = count_q > CW'(DEPTH - FETCH_WIDTH);
    assign accept   = fb.insts_in_valid & ~fb.stall & ~flush;
    assign deq      = fb.decode_ready & ~flush;

    always_comb begin
        n_in    = accept ? CW'(n_in_raw) : '0;
        n_out   = '0;
        if (deq) begin
            n_out = (count_q < CW'(DECODE_WIDTH)) ? count_q : CW'(DECODE_WIDTH);
        end
        head_d  = head_q + n_out[PW-1:0];
        tail_d  = tail_q + n_in[PW-1:0];
        count_d = count_q + n_in - n_out;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (accept && !reset) begin
            for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
                if (slot_valid[i]) begin
                    mem_q[tail_q + PW'(wr_off[i])] <= fb.insts_in[i];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
            fb.insts_out[i] = '0;
            if (!flush && !reset && (CW'(i) < count_q)) begin
                fb.insts_out[i] = mem_q[head_q + PW'(i)];
            end
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus random
// traffic compared each cycle against a queue-based reference model.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    fetch_buffer_if #(.FW(4), .DW(4)) bus ();

    fetch_buffer #(
        .DEPTH        (16),
        .FETCH_WIDTH  (4),
        .DECODE_WIDTH (4)
    ) dut (
        .clock (clk),
        .reset (rst),
        .flush (flush),
        .fb    (bus)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    fb_entry_t   model_q [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare outputs against the model, then
    // advance the model by the architectural rules at the rising edge.
    task automatic step(input logic iv, input logic [3:0] mask, input logic [31:0] pcb,
                        input logic dr, input logic fl, input logic rs);
        logic      exp_stall;
        fb_entry_t e;
        rst                 = rs;
        flush               = fl;
        bus.insts_in_valid  = iv;
        bus.decode_ready    = dr;
        for (int i = 0; i < 4; i++) begin
            bus.insts_in[i].valid      = mask[i];
            bus.insts_in[i].pc         = pcb + 32'(4 * i);
            bus.insts_in[i].inst       = $urandom;
            bus.insts_in[i].pred_taken = 1'($urandom_range(0, 1));
            bus.insts_in[i].pred_addr  = $urandom;
        end
        #1;
        exp_stall = (16 - model_q.size()) < 4;
        if (!rs) begin
            check("stall", 128'(bus.stall), 128'(exp_stall));
            check("count", 128'(dut.count_q), 128'(model_q.size()));
            for (int i = 0; i < 4; i++) begin
                e = '0;
                if (i < model_q.size() && !fl) e = model_q[i];
                check($sformatf("out%0d", i), 128'(bus.insts_out[i]), 128'(e));
            end
        end
        @(posedge clk);
        if (rs || fl) begin
            model_q.delete();
        end else begin
            if (dr) begin
                for (int k = 0; k < 4 && model_q.size() > 0; k++) void'(model_q.pop_front());
            end
            if (iv && !exp_stall) begin
                for (int i = 0; i < 4; i++) begin
                    if (mask[i]) model_q.push_back(bus.insts_in[i]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic dr);
        step(1'b0, 4'h0, 32'h0, dr, 1'b0, 1'b0);
    endtask

    function automatic logic [3:0] out_valids();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = bus.insts_out[i].valid;
        return v;
    endfunction

    initial begin
        rst                = 1'b1;
        flush              = 1'b0;
        bus.insts_in_valid = 1'b0;
        bus.decode_ready   = 1'b0;
        @(negedge clk);
        repeat (2) step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Idle after reset
        repeat (10) idle(1'b0);
        check("rst_stall", 128'(bus.stall), 128'(0));
        check("rst_valid", 128'(out_valids()), 128'(0));

        // Full bundle, no dequeue
        step(1'b1, 4'hF, 32'h00, 1'b0, 1'b0, 1'b0);
        check("full_cnt", 128'(dut.count_q), 128'(4));
        check("full_v",   128'(out_valids()), 128'(4'b1111));
        check("full_pc0", 128'(bus.insts_out[0].pc), 128'(32'h00));
        check("full_pc3", 128'(bus.insts_out[3].pc), 128'(32'h0C));
        idle(1'b1);

        // Sparse bundle: slots 0 and 2 valid compact into entries 0 and 1
        step(1'b1, 4'b0101, 32'h20, 1'b0, 1'b0, 1'b0);
        check("cmp_v",   128'(out_valids()), 128'(4'b0011));
        check("cmp_pc0", 128'(bus.insts_out[0].pc), 128'(32'h20));
        check("cmp_pc1", 128'(bus.insts_out[1].pc), 128'(32'h28));
        idle(1'b1);

        // Fill to 13, offered bundle ignored while stalled, drain to 9
        step(1'b1, 4'hF, 32'h40, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'hF, 32'h50, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'hF, 32'h60, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0001, 32'h70, 1'b0, 1'b0, 1'b0);
        check("st_on", 128'(bus.stall), 128'(1));
        step(1'b1, 4'hF, 32'h80, 1'b0, 1'b0, 1'b0);
        check("st_hold", 128'(dut.count_q), 128'(13));
        idle(1'b1);
        check("st_cnt9", 128'(dut.count_q), 128'(9));
        check("st_off",  128'(bus.stall), 128'(0));
        repeat (3) idle(1'b1);

        // Wrap: head primed to 14, bundle straddles index 15 -> 0
        step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'hF, 32'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'hF, 32'h10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'hF, 32'h20, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0011, 32'h30, 1'b0, 1'b0, 1'b0);
        repeat (4) idle(1'b1);
        check("wr_head", 128'(dut.head_q), 128'(14));
        step(1'b1, 4'hF, 32'h100, 1'b0, 1'b0, 1'b0);
        check("wr_pc0", 128'(bus.insts_out[0].pc), 128'(32'h100));
        check("wr_pc2", 128'(bus.insts_out[2].pc), 128'(32'h108));
        check("wr_pc3", 128'(bus.insts_out[3].pc), 128'(32'h10C));
        idle(1'b1);

        // Flush with simultaneous enqueue and dequeue at count 8
        step(1'b1, 4'hF, 32'h200, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'hF, 32'h210, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'hF, 32'h300, 1'b1, 1'b1, 1'b0);
        check("fl_cnt",   128'(dut.count_q), 128'(0));
        check("fl_stall", 128'(bus.stall), 128'(0));
        repeat (3) idle(1'b1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 9) < 7), 4'($urandom), $urandom & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter: DEPTH, default 16, entry count; power of two, at least 2*FETCH_WIDTH.
REQ-002 Parameter: FETCH_WIDTH, default 4, slots per enqueue bundle; taken from the shared header.
REQ-003 Parameter: DECODE_WIDTH, default 4, slots per dequeue bundle; taken from the shared header.
REQ-004 Port: clock  in  1  single clock; all state changes on the rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high.
REQ-006 Port: flush  in  1  squashes all buffered entries (mispredict or recovery).
REQ-007 Port: insts_in  in  fb_entry_t[FETCH_WIDTH]  fetch bundle; each slot has its own valid bit.
REQ-008 Port: insts_in_valid  in  1  bundle present.
REQ-009 Port: stall  out  1  buffer cannot accept a full bundle; fetch holds its PC.
REQ-010 Port: decode_ready  in  1  decode consumes the presented bundle this cycle.
REQ-011 Port: insts_out  out  fb_entry_t[DECODE_WIDTH]  oldest entries; slot valid bits mark occupancy.

Function
REQ-012 Storage: circular array of DEPTH fb_entry_t, with head pointer, tail pointer and count register (width log2(DEPTH)+1).
REQ-013 stall = (DEPTH - count) < FETCH_WIDTH. stall is combinational from registered count only and never depends on same-cycle dequeue.
REQ-014 Enqueue accept = insts_in_valid & ~stall & ~flush.
REQ-015 On accept, write only the slots with valid=1, in ascending slot order, compacted into consecutive entries starting at tail. tail and count advance by the number of valid slots (0..FETCH_WIDTH).
REQ-016 The compaction rule covers any valid pattern, for example 1010, not only prefix patterns.
REQ-017 Output slot i: valid = (i < count) & ~flush. It carries the entry at (head+i) mod DEPTH. Invalid slots drive all fields to 0.
REQ-018 Dequeue on decode_ready & ~flush. head advances and count decreases by min(count, DECODE_WIDTH).
REQ-019 Simultaneous enqueue and dequeue: next count = count + n_in - n_out, in one cycle.
REQ-020 Latency: an entry accepted in cycle N appears on insts_out in cycle N+1 at the earliest. There is no bypass from insts_in to insts_out.
REQ-021 Pointer arithmetic wraps modulo DEPTH. A bundle may straddle the wrap point.
REQ-022 Empty buffer (count=0): all output valid bits are 0. decode_ready is then a no-op.
REQ-023 Flush has priority over everything else. Next cycle: head = tail = count = 0. The same-cycle enqueue and dequeue are discarded, and all insts_out valid bits are 0 during the flush cycle.
REQ-024 Entry contents are passed through unmodified (inst, pc, pred_taken, pred_addr).
REQ-025 No entry is ever lost or duplicated. count never exceeds DEPTH and never underflows.

Reset
REQ-026 On reset: head = 0, tail = 0, count = 0, stall = 0, all insts_out valid bits and fields 0.
REQ-027 Reset asserted mid-operation discards all entries in the next cycle, the same as flush. Storage array contents need no reset.
REQ-028 If reset and flush are asserted together, reset wins; the result is identical.

Structure
REQ-029 fb_entry_t, FETCH_WIDTH and DECODE_WIDTH stay in the shared micro-op header. FB_DEPTH default is added there; no new types are defined locally.
REQ-030 One sub-module, fb_compact, SHALL be combinational. It maps FETCH_WIDTH valid bits to a per-slot write offset and a total count n_in.
REQ-031 The storage array SHALL be plain flops. No SRAM macro.

Verification
REQ-032 Reset, then idle: stall=0 and all 4 output valids are 0 for 10 cycles.
REQ-033 Enqueue bundle pc 0x00..0x0C (valid 1111) with decode_ready=0: next cycle count=4, outputs valid 1111 with pc 0x00,0x04,0x08,0x0C.
REQ-034 Enqueue valid 1010 (pc 0x20,0x28 valid): outputs hold pc 0x20 in slot 0, pc 0x28 in slot 1, and valid 0011.
REQ-035 Fill 13 entries with decode_ready=0: stall=1. An insts_in_valid bundle offered while stall=1 is ignored and count stays 13. Raise decode_ready: count becomes 9, then stall=0.
REQ-036 Prime head=14 and enqueue 4: entries land in indices 14,15,0,1. Dequeue returns them in order across the wrap.
REQ-037 With count=8, drive flush together with insts_in_valid and decode_ready in one cycle: that cycle outputs are invalid. Next cycle count=0, stall=0, and no flushed entry ever appears.
